// File: rtl/display_update_sched.sv
// ----------------------------------------------------------------------------
// display_update_sched
//
// Purpose:
//   Schedules refresh frames for the serial 7-segment output path. A request
//   (seconds tick, time-set increment or autonomous refresh tick) produces a
//   snapshot pulse that latches the current time into the display pipeline.
//   After the pipeline has settled, a start pulse launches the serializer.
//   The scheduler then follows the serializer's busy handshake. Requests that
//   arrive while a frame is in flight merge into one follow-up frame. The
//   block also generates the blinking colon.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous reset, active high
//   i_en           enable; low blocks new frames and clears queued requests
//   i_1hz_stb      seconds tick strobe (also toggles the colon)
//   i_set_stb      time-set increment strobe
//   i_set_active   set button held; forces the colon on
//   i_busy         serializer busy
//   o_snapshot_stb one-cycle pulse: latch time into the display pipeline
//   o_start_stb    one-cycle pulse: start a serializer frame
//   o_colon_blink  colon decimal-point drive
//   o_active       high while a frame is in progress
//   o_timeout      sticky handshake error, cleared only by reset
// ----------------------------------------------------------------------------
module display_update_sched #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int BUSY_TIMEOUT   = 1024,
    parameter int REFRESH_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_1hz_stb,
    input  logic i_set_stb,
    input  logic i_set_active,
    input  logic i_busy,
    output logic o_snapshot_stb,
    output logic o_start_stb,
    output logic o_colon_blink,
    output logic o_active,
    output logic o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT_ACK,
        ST_SHIFT
    } state_t;

    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam int REFRESH_W = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_settle_cnt;
    logic [7:0]  w_settle_cnt_next;
    logic [15:0] r_timeout_cnt;
    logic [15:0] w_timeout_cnt_next;
    logic        r_snapshot;
    logic        w_snapshot_next;
    logic        r_pending;
    logic        w_pending_next;
    logic        r_timeout;
    logic        w_set_timeout;
    logic        r_colon;
    logic        w_refresh_tick;
    logic        w_req;
    logic        w_go;

    // Autonomous refresh: counts enabled cycles and pulses on the last count.
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_CYCLES - 1);
            logic [REFRESH_W-1:0] r_refresh_cnt;

            always_ff @(posedge i_clk) begin
                if (i_reset || !i_en) begin
                    r_refresh_cnt <= '0;
                end else if (r_refresh_cnt == REFRESH_LAST) begin
                    r_refresh_cnt <= '0;
                end else begin
                    r_refresh_cnt <= r_refresh_cnt + REFRESH_W'(1);
                end
            end

            assign w_refresh_tick = i_en && (r_refresh_cnt == REFRESH_LAST);
        end else begin : g_no_refresh
            assign w_refresh_tick = 1'b0;
        end
    endgenerate

    assign w_req = i_en & (i_1hz_stb | i_set_stb | w_refresh_tick);
    // A queued request only launches while still enabled.
    assign w_go  = w_req | (r_pending & i_en);

    always_comb begin
        w_state_next       = r_state;
        w_settle_cnt_next  = r_settle_cnt;
        w_timeout_cnt_next = r_timeout_cnt;
        w_snapshot_next    = 1'b0;
        w_set_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_next      = ST_SETTLE;
                    w_settle_cnt_next = 8'd0;
                    w_snapshot_next   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_START;
                end else begin
                    w_settle_cnt_next = r_settle_cnt + 8'd1;
                end
            end
            ST_START: begin
                w_state_next       = ST_WAIT_ACK;
                w_timeout_cnt_next = 16'd0;
            end
            ST_WAIT_ACK: begin
                if (i_busy) begin
                    w_state_next       = ST_SHIFT;
                    w_timeout_cnt_next = 16'd0;
                end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                    w_state_next  = ST_IDLE;
                    w_set_timeout = 1'b1;
                end else begin
                    w_timeout_cnt_next = r_timeout_cnt + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (!i_busy) begin
                    w_state_next = ST_IDLE;
                end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                    w_state_next  = ST_IDLE;
                    w_set_timeout = 1'b1;
                end else begin
                    w_timeout_cnt_next = r_timeout_cnt + 16'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Requests seen outside IDLE (including the cycle that returns to IDLE)
    // collapse into a single queued frame.
    always_comb begin
        w_pending_next = r_pending;
        if (!i_en) begin
            w_pending_next = 1'b0;
        end else if (r_state != ST_IDLE) begin
            w_pending_next = r_pending | w_req;
        end else if (w_go) begin
            w_pending_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_settle_cnt  <= 8'd0;
            r_timeout_cnt <= 16'd0;
            r_snapshot    <= 1'b0;
            r_pending     <= 1'b0;
            r_timeout     <= 1'b0;
            r_colon       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_settle_cnt  <= w_settle_cnt_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_snapshot    <= w_snapshot_next;
            r_pending     <= w_pending_next;
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
            // Holding the flop at 1 while setting makes the first tick after
            // release turn the colon off.
            if (i_en) begin
                if (i_set_active) begin
                    r_colon <= 1'b1;
                end else if (i_1hz_stb) begin
                    r_colon <= ~r_colon;
                end
            end
        end
    end

    assign o_snapshot_stb = r_snapshot;
    assign o_start_stb    = (r_state == ST_START);
    assign o_active       = (r_state != ST_IDLE);
    assign o_timeout      = r_timeout;
    assign o_colon_blink  = r_colon | (i_en & i_set_active);

endmodule

// File: tb/tb_display_update_sched.sv
module tb_display_update_sched;

    localparam int S  = 4;
    localparam int TA = 1024;
    localparam int TB = 16;
    localparam int RC = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en = 1'b0;
    logic hz = 1'b0;
    logic sstb = 1'b0;
    logic sact = 1'b0;

    logic snap_a, start_a, col_a, act_a, to_a;
    logic snap_b, start_b, col_b, act_b, to_b;
    logic snap_c, start_c, col_c, act_c, to_c;

    wire [2:0] busy_w;
    wire [2:0] start_w = {start_c, start_b, start_a};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int bm_delay[3];
    int bm_len[3];
    bit bm_never[3];
    bit bm_rand[3];

    int n_pass = 0;
    int n_total = 0;

    display_update_sched #(.SETTLE_CYCLES(S), .BUSY_TIMEOUT(TA), .REFRESH_CYCLES(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(sstb),
        .i_set_active(sact), .i_busy(busy_w[0]), .o_snapshot_stb(snap_a),
        .o_start_stb(start_a), .o_colon_blink(col_a), .o_active(act_a), .o_timeout(to_a));

    display_update_sched #(.SETTLE_CYCLES(S), .BUSY_TIMEOUT(TB), .REFRESH_CYCLES(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(sstb),
        .i_set_active(sact), .i_busy(busy_w[1]), .o_snapshot_stb(snap_b),
        .o_start_stb(start_b), .o_colon_blink(col_b), .o_active(act_b), .o_timeout(to_b));

    display_update_sched #(.SETTLE_CYCLES(S), .BUSY_TIMEOUT(TA), .REFRESH_CYCLES(RC)) u_c (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(sstb),
        .i_set_active(sact), .i_busy(busy_w[2]), .o_snapshot_stb(snap_c),
        .o_start_stb(start_c), .o_colon_blink(col_c), .o_active(act_c), .o_timeout(to_c));

    // Serializer models: after a start pulse, raise busy after a delay and
    // hold it for a length of cycles (or never answer).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bm
            logic b = 1'b0;
            int wait_left = 0;
            int hold_left = 0;
            int dly = 1;
            int ln = 1;
            bit nev = 1'b0;
            assign busy_w[gi] = b;
            always @(negedge clk) begin
                if (rst) begin
                    b = 1'b0;
                    wait_left = 0;
                    hold_left = 0;
                end else if (start_w[gi]) begin
                    if (bm_rand[gi]) begin
                        nev = ($urandom_range(0, 29) == 0);
                        dly = $urandom_range(1, 4);
                        ln  = $urandom_range(1, 40);
                    end else begin
                        nev = bm_never[gi];
                        dly = bm_delay[gi];
                        ln  = bm_len[gi];
                    end
                    if (!nev) wait_left = dly;
                end else if (hold_left > 0) begin
                    hold_left--;
                    if (hold_left == 0) b = 1'b0;
                end else if (wait_left > 0) begin
                    wait_left--;
                    if (wait_left == 0) begin
                        b = 1'b1;
                        hold_left = ln;
                    end
                end
            end
        end
    endgenerate

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit en_val);
        rst = 1'b1; hz = 1'b0; sstb = 1'b0; sact = 1'b0; en = en_val;
        repeat (3) nstep();
        rst = 1'b0;
    endtask

    task automatic cfg_bm(input int idx, input int d, input int l, input bit nv);
        bm_delay[idx] = d; bm_len[idx] = l; bm_never[idx] = nv; bm_rand[idx] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_total++;
        if ({snap_a, start_a, col_a, act_a, to_a} !== 5'b0) $display("FAIL reset_a: got %b expected 00000", {snap_a, start_a, col_a, act_a, to_a});
        else n_pass++;
        n_total++;
        if ({snap_b, start_b, col_b, act_b, to_b} !== 5'b0) $display("FAIL reset_b: got %b expected 00000", {snap_b, start_b, col_b, act_b, to_b});
        else n_pass++;
        n_total++;
        if ({snap_c, start_c, col_c, act_c, to_c} !== 5'b0) $display("FAIL reset_c: got %b expected 00000", {snap_c, start_c, col_c, act_c, to_c});
        else n_pass++;
        $display("reset: outputs a=%b b=%b c=%b", {snap_a, start_a, col_a, act_a, to_a},
                 {snap_b, start_b, col_b, act_b, to_b}, {snap_c, start_c, col_c, act_c, to_c});
    endtask

    task automatic test_basic();
        int t0 = 0, fsnap = -1, fstart = -1, nsnap = 0, afall = -1;
        bit pa = 1'b0;
        do_reset(1'b1);
        cfg_bm(0, 2, 96, 1'b0);
        for (int k = 0; k < 140; k++) begin
            nstep();
            if (k == 0) t0 = cyc;
            if (snap_a) begin nsnap++; if (fsnap < 0) fsnap = cyc; end
            if (start_a && fstart < 0) fstart = cyc;
            if (pa && !act_a && afall < 0) afall = cyc;
            pa = act_a;
            hz = (k == 0);
        end
        $display("basic: tick @%0d snapshot @%0d start @%0d idle @%0d", t0, fsnap, fstart, afall);
        n_total++;
        if (fsnap !== t0 + 1) $display("FAIL basic_snapshot: got %0d expected %0d", fsnap, t0 + 1); else n_pass++;
        n_total++;
        if (fstart !== t0 + 5) $display("FAIL basic_start: got %0d expected %0d", fstart, t0 + 5); else n_pass++;
        n_total++;
        if (afall !== t0 + 104) $display("FAIL basic_idle: got %0d expected %0d", afall, t0 + 104); else n_pass++;
        n_total++;
        if (nsnap !== 1) $display("FAIL basic_count: got %0d expected 1", nsnap); else n_pass++;
        n_total++;
        if (col_a !== 1'b1) $display("FAIL basic_colon: got %b expected 1", col_a); else n_pass++;
    endtask

    task automatic test_coalesce();
        int t0 = 0, nsnap = 0, nstart = 0;
        int sc[4];
        int st[4];
        do_reset(1'b1);
        cfg_bm(0, 2, 40, 1'b0);
        for (int k = 0; k < 200; k++) begin
            nstep();
            if (k == 0) t0 = cyc;
            if (snap_a) begin if (nsnap < 4) sc[nsnap] = cyc; nsnap++; end
            if (start_a) begin if (nstart < 4) st[nstart] = cyc; nstart++; end
            hz = (k == 0);
            sstb = (k == 12 || k == 20 || k == 30);
        end
        $display("coalesce: frames=%0d second snapshot @%0d (tick @%0d)", nsnap, (nsnap > 1) ? sc[1] : -1, t0);
        n_total++;
        if (nsnap !== 2) $display("FAIL coalesce_snapshots: got %0d expected 2", nsnap); else n_pass++;
        n_total++;
        if (nstart !== 2) $display("FAIL coalesce_starts: got %0d expected 2", nstart); else n_pass++;
        n_total++;
        if (nsnap < 2 || sc[1] !== t0 + 49) $display("FAIL coalesce_snap2: got %0d expected %0d", (nsnap > 1) ? sc[1] : -1, t0 + 49); else n_pass++;
        n_total++;
        if (nstart < 2 || st[1] !== t0 + 53) $display("FAIL coalesce_start2: got %0d expected %0d", (nstart > 1) ? st[1] : -1, t0 + 53); else n_pass++;
    endtask

    task automatic test_timeout();
        int t0 = 0, torise = -1, nsnap = 0;
        int sc[8];
        logic act_at = 1'bx;
        logic pt = 1'b0;
        do_reset(1'b1);
        cfg_bm(1, 1, 1, 1'b1);
        for (int k = 0; k < 120; k++) begin
            nstep();
            if (k == 0) t0 = cyc;
            if (snap_b) begin if (nsnap < 8) sc[nsnap] = cyc; nsnap++; end
            if (to_b && !pt) begin torise = cyc; act_at = act_b; end
            pt = to_b;
            hz = (k == 0 || k == 70);
            sstb = (k == 8);
        end
        $display("timeout: tick @%0d timeout @%0d snapshots=%0d", t0, torise, nsnap);
        n_total++;
        if (torise !== t0 + 22) $display("FAIL timeout_cycle: got %0d expected %0d", torise, t0 + 22); else n_pass++;
        n_total++;
        if (act_at !== 1'b0) $display("FAIL timeout_idle: got %b expected 0", act_at); else n_pass++;
        n_total++;
        if (nsnap !== 3) $display("FAIL timeout_snapshots: got %0d expected 3", nsnap); else n_pass++;
        n_total++;
        if (nsnap < 2 || sc[1] !== t0 + 23) $display("FAIL timeout_retry: got %0d expected %0d", (nsnap > 1) ? sc[1] : -1, t0 + 23); else n_pass++;
        n_total++;
        if (nsnap < 3 || sc[2] !== t0 + 71) $display("FAIL timeout_later_snap: got %0d expected %0d", (nsnap > 2) ? sc[2] : -1, t0 + 71); else n_pass++;
        n_total++;
        if (to_b !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", to_b); else n_pass++;
        rst = 1'b1;
        nstep();
        rst = 1'b0;
        n_total++;
        if (to_b !== 1'b0) $display("FAIL timeout_clear: got %b expected 0", to_b); else n_pass++;
    endtask

    task automatic test_refresh();
        int m = 0, nc = 0, na = 0, first = -1, last = -1;
        bit spacing_ok = 1'b1;
        do_reset(1'b0);
        cfg_bm(0, 1, 3, 1'b0);
        cfg_bm(2, 1, 3, 1'b0);
        for (int k = 0; k < 1040; k++) begin
            nstep();
            if (k == 0) m = cyc;
            if (snap_c) begin
                if (first < 0) first = cyc;
                else if (cyc - last != RC) spacing_ok = 1'b0;
                last = cyc;
                nc++;
            end
            if (snap_a) na++;
            en = (k < 1000);
        end
        $display("refresh: frames=%0d first @%0d (enable @%0d), disabled instance frames=%0d", nc, first, m, na);
        n_total++;
        if (nc !== 10) $display("FAIL refresh_count: got %0d expected 10", nc); else n_pass++;
        n_total++;
        if (first !== m + RC) $display("FAIL refresh_first: got %0d expected %0d", first, m + RC); else n_pass++;
        n_total++;
        if (spacing_ok !== 1'b1) $display("FAIL refresh_spacing: got irregular expected %0d", RC); else n_pass++;
        n_total++;
        if (na !== 0) $display("FAIL refresh_disabled: got %0d expected 0", na); else n_pass++;
    endtask

    task automatic test_colon();
        bit all_one = 1'b1;
        do_reset(1'b1);
        sact = 1'b1;
        nstep();
        for (int p = 0; p < 4; p++) begin
            hz = 1'b1; nstep(); hz = 1'b0;
            repeat (3) begin nstep(); if (col_a !== 1'b1) all_one = 1'b0; end
        end
        n_total++;
        if (all_one !== 1'b1) $display("FAIL colon_forced: got 0 expected 1"); else n_pass++;
        sact = 1'b0;
        nstep(); nstep();
        n_total++;
        if (col_a !== 1'b1) $display("FAIL colon_release: got %b expected 1", col_a); else n_pass++;
        hz = 1'b1; nstep(); hz = 1'b0; nstep();
        n_total++;
        if (col_a !== 1'b0) $display("FAIL colon_first_tick: got %b expected 0", col_a); else n_pass++;
        hz = 1'b1; nstep(); hz = 1'b0; nstep();
        n_total++;
        if (col_a !== 1'b1) $display("FAIL colon_second_tick: got %b expected 1", col_a); else n_pass++;
        $display("colon: forced=%b after two ticks=%b", all_one, col_a);
    endtask

    task automatic test_en_drop();
        int t0 = 0, nsnap = 0, nstart = 0, afall = -1;
        bit pa = 1'b0;
        do_reset(1'b1);
        cfg_bm(0, 2, 30, 1'b0);
        for (int k = 0; k < 120; k++) begin
            nstep();
            if (k == 0) t0 = cyc;
            if (snap_a) nsnap++;
            if (start_a) nstart++;
            if (pa && !act_a && afall < 0) afall = cyc;
            pa = act_a;
            hz = (k == 0);
            sstb = (k == 15);
            en = !(k >= 20 && k < 80);
        end
        $display("en_drop: snapshots=%0d starts=%0d idle @%0d", nsnap, nstart, afall);
        n_total++;
        if (afall !== t0 + 38) $display("FAIL en_drop_complete: got %0d expected %0d", afall, t0 + 38); else n_pass++;
        n_total++;
        if (nstart !== 1) $display("FAIL en_drop_starts: got %0d expected 1", nstart); else n_pass++;
        n_total++;
        if (nsnap !== 1) $display("FAIL en_drop_snapshots: got %0d expected 1", nsnap); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0 = 0, nsnap = 0, nstart = 0;
        logic [4:0] after = 5'bx;
        do_reset(1'b1);
        for (int k = 0; k < 40; k++) begin
            nstep();
            if (k == 0) t0 = cyc;
            if (snap_a) nsnap++;
            if (start_a) nstart++;
            if (cyc == t0 + 3) after = {snap_a, start_a, col_a, act_a, to_a};
            hz = (k == 0);
            rst = (k == 2);
        end
        $display("reset_mid: snapshots=%0d starts=%0d outputs after reset=%b", nsnap, nstart, after);
        n_total++;
        if (after !== 5'b0) $display("FAIL reset_mid_outputs: got %b expected 00000", after); else n_pass++;
        n_total++;
        if (nstart !== 0) $display("FAIL reset_mid_starts: got %0d expected 0", nstart); else n_pass++;
        n_total++;
        if (nsnap !== 1) $display("FAIL reset_mid_snapshots: got %0d expected 1", nsnap); else n_pass++;
    endtask

    // Reference: a frame is described by its snapshot time; settle, start and
    // handshake windows are derived from elapsed cycles since that time.
    task automatic test_random();
        bit on = 1'b0, acked = 1'b0, pend = 1'b0, tmo = 1'b0, col = 1'b0, ended, req, bsy;
        int tsnap = 0, tphase = 0, c, fails = 0, frames = 0;
        logic [4:0] exp_v, got_v;
        bit e_snap = 1'b0, e_start = 1'b0;
        do_reset(1'b1);
        bm_rand[0] = 1'b1;
        for (int i = 0; i < 4000 && fails < 5; i++) begin
            got_v = {snap_a, start_a, act_a, to_a, col_a};
            exp_v = {e_snap, e_start, on, tmo, col | (en & sact)};
            n_total++;
            if (got_v !== exp_v) begin
                $display("FAIL random_cycle%0d: got %b expected %b (snap,start,active,timeout,colon)", cyc, got_v, exp_v);
                fails++;
            end else n_pass++;
            if (snap_a && e_snap) begin
                frames++;
                $display("random: frame %0d snapshot @%0d", frames, cyc);
            end
            hz   = ($urandom_range(0, 24) == 0);
            sstb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) sact = ~sact;
            if ($urandom_range(0, 119) == 0) en = ~en;
            bsy = busy_w[0];
            c = cyc;
            req = en & (hz | sstb);
            ended = 1'b0;
            if (on) begin
                if (c - tsnap > S) begin
                    if (!acked) begin
                        if (bsy) begin acked = 1'b1; tphase = c + 1; end
                        else if (c - (tsnap + S + 1) == TA - 1) begin tmo = 1'b1; ended = 1'b1; end
                    end else begin
                        if (!bsy) ended = 1'b1;
                        else if (c - tphase == TA - 1) begin tmo = 1'b1; ended = 1'b1; end
                    end
                end
                if (req) pend = 1'b1;
                if (!en) pend = 1'b0;
                if (ended) on = 1'b0;
            end else if (req || (pend && en)) begin
                on = 1'b1; tsnap = c + 1; acked = 1'b0; pend = 1'b0;
            end else if (!en) pend = 1'b0;
            if (en) begin
                if (sact) col = 1'b1;
                else if (hz) col = ~col;
            end
            e_snap  = on && (c + 1 == tsnap);
            e_start = on && (c + 1 - tsnap == S);
            nstep();
        end
        bm_rand[0] = 1'b0;
        $display("random: %0d frames, %0d mismatching cycles", frames, fails);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cfg_bm(i, 1, 3, 1'b0);
        test_reset();
        test_basic();
        test_coalesce();
        test_timeout();
        test_refresh();
        test_colon();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_update_sched.md
Name: display_update_sched

Overview:
- Sequences the serial 7-segment shift-out path.
- Decides when the displayed time is snapshotted and when a shift-out frame starts.
- Tracks the shifter's busy handshake, coalesces update requests, and generates the colon blink signal.
- Sits between the timing strobes/clock register and the output serializer's start/busy interface.

Parameters:
- SETTLE_CYCLES, 4, cycles from snapshot strobe to start strobe (covers binary-to-BCD/7-seg pipeline); legal 1..255.
- BUSY_TIMEOUT, 1024, max cycles waited in each busy phase before abort; legal 2..65535.
- REFRESH_CYCLES, 500000, period of autonomous refresh request (10 Hz at 5 MHz); 0 disables.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous reset, active high.
- i_en  input  1  enable; low blocks new frames.
- i_1hz_stb  input  1  one-cycle strobe, seconds tick.
- i_set_stb  input  1  one-cycle strobe, time-set increment applied.
- i_set_active  input  1  level, hours or minutes set button held (debounced).
- i_busy  input  1  serializer busy.
- o_snapshot_stb  output  1  one-cycle pulse: latch current time into display pipeline.
- o_start_stb  output  1  one-cycle pulse: start serializer frame.
- o_colon_blink  output  1  colon decimal-point drive.
- o_active  output  1  high whenever state != IDLE.
- o_timeout  output  1  sticky error, serializer failed handshake.

Behaviour:
- Reset: state IDLE; all outputs 0; pending=0; refresh counter=0; settle/timeout counters=0.
- Request: req = i_en & (i_1hz_stb | i_set_stb | refresh_tick). refresh_tick is a one-cycle pulse when the refresh counter reaches REFRESH_CYCLES-1; the counter then wraps to 0. The refresh counter runs only while i_en=1 and is cleared when i_en=0.
- States:
  - IDLE:
    - If req or pending: o_snapshot_stb=1 next cycle, clear pending, go SETTLE with counter=0.
  - SETTLE:
    - Count to SETTLE_CYCLES-1, then go START.
    - o_start_stb asserts exactly SETTLE_CYCLES cycles after o_snapshot_stb.
  - START:
    - o_start_stb high for this single cycle; go WAIT_ACK with timeout counter=0.
  - WAIT_ACK:
    - If i_busy=1: go SHIFT with timeout counter=0.
    - Else if counter = BUSY_TIMEOUT-1: set o_timeout, go IDLE.
  - SHIFT:
    - If i_busy=0: go IDLE.
    - Else if counter = BUSY_TIMEOUT-1: set o_timeout, go IDLE.
- Coalescing:
  - Any req while state != IDLE sets pending; multiple requests collapse into one frame.
  - A req in the same cycle as a return to IDLE also sets pending.
  - From IDLE with pending, the next frame's snapshot issues on the following cycle, giving a one-cycle IDLE gap between frames.
- Frame completion: a frame in progress always completes, even if i_en falls. i_en=0 clears pending and suppresses new req.
- Colon:
  - o_colon_blink toggles on each i_1hz_stb (0.5 Hz square wave).
  - While i_set_active=1, o_colon_blink is forced 1 and the toggle flop is held at 1.
  - On release, the next i_1hz_stb toggles it to 0.
  - i_en=0 holds the current value.
- o_timeout is cleared only by i_reset. A timeout does not clear pending: a request arriving mid-frame retries once back in IDLE.
- Reset mid-frame: returns to IDLE in the next cycle. A start strobe already issued is not recalled.
- Counter widths: settle counter 8 bits; timeout counter 16 bits; refresh counter $clog2(REFRESH_CYCLES+1) bits, minimum 1.

Test Plan:
- Reset then i_1hz_stb at cycle 10, busy model rises 2 cycles after start and holds 96 cycles -> o_snapshot_stb at 11, o_start_stb at 15, o_active low again the cycle after busy falls, o_colon_blink=1.
- Three i_set_stb pulses during one frame's SHIFT phase -> exactly one further snapshot/start pair, issued 2 cycles after busy falls; no third frame.
- i_busy never asserts, BUSY_TIMEOUT=16 -> o_timeout=1 at start+17, state IDLE, subsequent i_1hz_stb still produces a snapshot; o_timeout stays 1 until reset.
- REFRESH_CYCLES=100, no strobes, i_en=1 for 1000 cycles, fast busy model -> 10 frames at 100-cycle spacing; with REFRESH_CYCLES=0 -> zero frames.
- i_set_active=1 across four i_1hz_stb -> o_colon_blink stuck 1; after release, next stb -> 0, following stb -> 1.
- i_en dropped mid-SHIFT with a pending request -> current frame completes, no further start; i_reset asserted in SETTLE -> no o_start_stb, all outputs 0 the next cycle.
